// File: rtl/i3c_bus_filter_if.sv
// Pad-side and core-side signals of the I3C bus input conditioning stage.
// slave: the filter itself; master: whatever drives the pads and consumes the results.
interface i3c_bus_filter_if;
  logic scl_i;
  logic sda_i;
  logic scl_o;
  logic sda_o;
  logic scl_posedge_o;
  logic scl_negedge_o;
  logic start_det_o;
  logic rstart_det_o;
  logic stop_det_o;
  logic bus_busy_o;
  logic bus_idle_o;

  modport slave (
    input  scl_i, sda_i,
    output scl_o, sda_o, scl_posedge_o, scl_negedge_o,
           start_det_o, rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o
  );

  modport master (
    output scl_i, sda_i,
    input  scl_o, sda_o, scl_posedge_o, scl_negedge_o,
           start_det_o, rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o
  );
endinterface

// File: rtl/i3c_bus_filter.sv
// I3C bus input conditioning: synchroniser, spike filter, SCL edges, START/Sr/STOP, busy/idle.
// Optional spike filter enabled by defining I3C_GLITCH_FILTER_EN.
module i3c_bus_filter #(
  parameter int SyncStages = 2,
  parameter int FiltCntW   = 8,
  parameter int IdleCntW   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [FiltCntW-1:0] filt_cycles_i,
  input  logic [IdleCntW-1:0] idle_cycles_i,
  i3c_bus_filter_if.slave     bus
);
  // Line index 0 is SCL, index 1 is SDA throughout.
  logic [1:0]            raw_s;
  logic [1:0]            syn_s;
  logic [SyncStages-1:0] sync_q [2];
  logic [SyncStages-1:0] sync_d [2];
  logic [1:0]            syn_prev_q, syn_prev_d;
  logic [1:0]            filt_q, filt_d;
  logic                  scl_pos_q, scl_pos_d;
  logic                  scl_neg_q, scl_neg_d;
  logic                  start_det_q, start_det_d;
  logic                  rstart_det_q, rstart_det_d;
  logic                  stop_det_q, stop_det_d;
  logic                  busy_q, busy_d;
  logic                  idle_q, idle_d;
  logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;
  logic                  scl_hi_s, start_s, stop_s, qual_cur_s, qual_nxt_s;

  assign raw_s = {bus.sda_i, bus.scl_i};

`ifdef I3C_GLITCH_FILTER_EN
  logic [FiltCntW-1:0] fcnt_q [2];
  logic [FiltCntW-1:0] fcnt_d [2];
`else
  logic unused_filt_s;
  assign unused_filt_s = ^filt_cycles_i;
`endif

  // Synchroniser shift and per-line level acceptance.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SyncStages-2:0], raw_s[i]};
      syn_s[i]  = sync_q[i][SyncStages-1];
    end
    syn_prev_d = syn_s;
    filt_d     = filt_q;
`ifdef I3C_GLITCH_FILTER_EN
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if ((syn_s[i] == filt_q[i]) || (syn_s[i] != syn_prev_q[i])) begin
        fcnt_d[i] = {FiltCntW{1'b0}};
      end else if (fcnt_q[i] != {FiltCntW{1'b1}}) begin
        fcnt_d[i] = fcnt_q[i] + {{(FiltCntW-1){1'b0}}, 1'b1};
      end else begin
        fcnt_d[i] = fcnt_q[i];
      end
      // A level is accepted only once it has held for at least one cycle past its change.
      if ((syn_s[i] != filt_q[i]) && (syn_s[i] == syn_prev_q[i]) && (fcnt_q[i] >= filt_cycles_i)) begin
        filt_d[i] = syn_s[i];
      end else begin
        filt_d[i] = filt_q[i];
      end
    end
`else
    // Taking the delayed synced value keeps latency equal to the filter at a zero threshold.
    filt_d = syn_prev_q;
`endif
  end

  // Edge strobes, bus conditions, busy flag and idle counter from the next filtered levels.
  always_comb begin
    scl_pos_d    = filt_d[0] & ~filt_q[0];
    scl_neg_d    = ~filt_d[0] & filt_q[0];
    scl_hi_s     = filt_q[0] & filt_d[0];
    start_s      = enable_i & scl_hi_s & filt_q[1] & ~filt_d[1];
    stop_s       = enable_i & scl_hi_s & ~filt_q[1] & filt_d[1];
    start_det_d  = start_s & ~busy_q;
    rstart_det_d = start_s & busy_q;
    stop_det_d   = stop_s;
    if (!enable_i) begin
      busy_d = 1'b0;
    end else if (start_det_q || rstart_det_q) begin
      busy_d = 1'b1;
    end else if (stop_det_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    qual_cur_s = enable_i & filt_q[0] & filt_q[1] & ~busy_q;
    if (!qual_cur_s) begin
      idle_cnt_d = {IdleCntW{1'b0}};
    end else if (idle_cnt_q != {IdleCntW{1'b1}}) begin
      idle_cnt_d = idle_cnt_q + {{(IdleCntW-1){1'b0}}, 1'b1};
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    qual_nxt_s = enable_i & filt_d[0] & filt_d[1] & ~busy_d;
    idle_d     = qual_nxt_s & (idle_cnt_d >= idle_cycles_i);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {SyncStages{1'b1}};
      end
      syn_prev_q   <= 2'b11;
      filt_q       <= 2'b11;
      scl_pos_q    <= 1'b0;
      scl_neg_q    <= 1'b0;
      start_det_q  <= 1'b0;
      rstart_det_q <= 1'b0;
      stop_det_q   <= 1'b0;
      busy_q       <= 1'b0;
      idle_q       <= 1'b0;
      idle_cnt_q   <= {IdleCntW{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
      end
      syn_prev_q   <= syn_prev_d;
      filt_q       <= filt_d;
      scl_pos_q    <= scl_pos_d;
      scl_neg_q    <= scl_neg_d;
      start_det_q  <= start_det_d;
      rstart_det_q <= rstart_det_d;
      stop_det_q   <= stop_det_d;
      busy_q       <= busy_d;
      idle_q       <= idle_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

`ifdef I3C_GLITCH_FILTER_EN
  // Spike-filter counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i] <= {FiltCntW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end
`endif

  assign bus.scl_o         = filt_q[0];
  assign bus.sda_o         = filt_q[1];
  assign bus.scl_posedge_o = scl_pos_q;
  assign bus.scl_negedge_o = scl_neg_q;
  assign bus.start_det_o   = start_det_q;
  assign bus.rstart_det_o  = rstart_det_q;
  assign bus.stop_det_o    = stop_det_q;
  assign bus.bus_busy_o    = busy_q;
  assign bus.bus_idle_o    = idle_q;
endmodule

// File: tb/tb_i3c_bus_filter.sv
// Bench for i3c_bus_filter: directed test-plan steps plus random line activity,
// every cycle compared against a run-length/queue reference model.
module tb_i3c_bus_filter;
  localparam int S = 2;
`ifdef I3C_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  filt_n;
  logic [15:0] idle_n;
  int checks   = 0;
  int failures = 0;

  i3c_bus_filter_if bus_if ();

  i3c_bus_filter #(.SyncStages(S), .FiltCntW(8), .IdleCntW(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (en),
    .filt_cycles_i(filt_n),
    .idle_cycles_i(idle_n),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: pin sample history, synced run lengths, accepted levels.
  logic [1:0] hist [$];
  logic [1:0] syn_c, syn_l, m_filt;
  int         run [2];
  logic       m_pos, m_neg, m_start, m_rstart, m_stop, m_busy, m_idle;
  int         icnt;
  int n_pos, n_neg, n_start, n_rstart, n_stop, n_busy, n_idle;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < S; i++) hist.push_back(2'b11);
    syn_c = 2'b11; syn_l = 2'b11; m_filt = 2'b11;
    run[0] = 1; run[1] = 1;
    m_pos = 1'b0; m_neg = 1'b0; m_start = 1'b0; m_rstart = 1'b0; m_stop = 1'b0;
    m_busy = 1'b0; m_idle = 1'b0; icnt = 0;
  endtask

  task automatic model_edge(input logic [1:0] pins);
    logic [1:0] oldf, newf, nsyn;
    logic hi, st, sp, nb, qold;
    if (rst) begin
      model_reset();
    end else begin
      oldf = m_filt;
      newf = oldf;
      for (int i = 0; i < 2; i++) begin
        if (FILT_EN) begin
          if (syn_c[i] != oldf[i] && run[i] >= int'(filt_n) + 2) newf[i] = syn_c[i];
        end else begin
          newf[i] = syn_l[i];
        end
      end
      m_pos = newf[0] & ~oldf[0];
      m_neg = ~newf[0] & oldf[0];
      hi = oldf[0] & newf[0];
      st = en & hi & oldf[1] & ~newf[1];
      sp = en & hi & ~oldf[1] & newf[1];
      nb = !en ? 1'b0 : (m_start | m_rstart) ? 1'b1 : m_stop ? 1'b0 : m_busy;
      m_start  = st & ~m_busy;
      m_rstart = st & m_busy;
      m_stop   = sp;
      qold = en & oldf[0] & oldf[1] & ~m_busy;
      icnt = qold ? ((icnt < 65535) ? icnt + 1 : icnt) : 0;
      m_busy = nb;
      m_idle = en & newf[0] & newf[1] & ~nb & (icnt >= int'(idle_n));
      m_filt = newf;
      hist.push_back(pins);
      void'(hist.pop_front());
      nsyn = hist[0];
      for (int i = 0; i < 2; i++) begin
        run[i] = (nsyn[i] == syn_c[i]) ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 1;
      end
      syn_l = syn_c;
      syn_c = nsyn;
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_pos = 0; n_neg = 0; n_start = 0; n_rstart = 0; n_stop = 0; n_busy = 0; n_idle = 0;
  endtask

  task automatic step(input logic scl, input logic sda);
    bus_if.scl_i = scl;
    bus_if.sda_i = sda;
    @(posedge clk);
    model_edge({sda, scl});
    #1;
    chk("scl_o", bus_if.scl_o, m_filt[0]);
    chk("sda_o", bus_if.sda_o, m_filt[1]);
    chk("scl_posedge_o", bus_if.scl_posedge_o, m_pos);
    chk("scl_negedge_o", bus_if.scl_negedge_o, m_neg);
    chk("start_det_o", bus_if.start_det_o, m_start);
    chk("rstart_det_o", bus_if.rstart_det_o, m_rstart);
    chk("stop_det_o", bus_if.stop_det_o, m_stop);
    chk("bus_busy_o", bus_if.bus_busy_o, m_busy);
    chk("bus_idle_o", bus_if.bus_idle_o, m_idle);
    n_pos += int'(bus_if.scl_posedge_o);
    n_neg += int'(bus_if.scl_negedge_o);
    n_start += int'(bus_if.start_det_o);
    n_rstart += int'(bus_if.rstart_det_o);
    n_stop += int'(bus_if.stop_det_o);
    n_busy += int'(bus_if.bus_busy_o);
    n_idle += int'(bus_if.bus_idle_o);
  endtask

  task automatic hold(input logic scl, input logic sda, input int n);
    repeat (n) step(scl, sda);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [1:0] rp;
    model_reset();
    clear_counts();
    rst = 1'b1; en = 1'b1; filt_n = 8'd3; idle_n = 16'd10;
    bus_if.scl_i = 1'b0; bus_if.sda_i = 1'b0;

    // Reset held three cycles with both pins low.
    hold(1'b0, 1'b0, 3);
    chk("reset_scl_high", bus_if.scl_o, 1'b1);
    chk("reset_sda_high", bus_if.sda_o, 1'b1);
    rst = 1'b0;
    step(1'b0, 1'b0);
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      step(1'b0, 1'b0);
      if (lat == 0 && bus_if.scl_o === 1'b0) lat = j;
    end
    chk_int("release_latency", lat, FILT_EN ? S + 3 + 1 : S + 1);
    hold(1'b1, 1'b1, 15);

    // Glitch rejection at threshold 3.
    clear_counts();
    hold(1'b0, 1'b1, 3);
    hold(1'b1, 1'b1, 15);
    chk_int("glitch3_negedges", n_neg, FILT_EN ? 0 : 1);
    step(1'b0, 1'b1);
    lat = 0;
    for (int j = 1; j <= 30; j++) begin
      step((j < 5) ? 1'b0 : 1'b1, 1'b1);
      if (lat == 0 && bus_if.scl_negedge_o === 1'b1) lat = j;
    end
    chk_int("glitch5_latency", lat, FILT_EN ? 6 : 3);

    // START, Repeated START, STOP.
    clear_counts();
    hold(1'b1, 1'b0, 12);
    chk_int("start_count", n_start, 1);
    chk_int("start_no_rstart", n_rstart, 0);
    chk("busy_after_start", bus_if.bus_busy_o, 1'b1);
    clear_counts();
    hold(1'b0, 1'b0, 12); hold(1'b0, 1'b1, 12); hold(1'b1, 1'b1, 12); hold(1'b1, 1'b0, 12);
    chk_int("rstart_count", n_rstart, 1);
    chk_int("rstart_no_start", n_start, 0);
    clear_counts();
    hold(1'b1, 1'b1, 12);
    chk_int("stop_count", n_stop, 1);
    chk("busy_after_stop", bus_if.bus_busy_o, 1'b0);

    // Reset mid-transfer, then a STOP while not busy.
    hold(1'b1, 1'b0, 12);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk("busy_in_reset", bus_if.bus_busy_o, 1'b0);
    hold(1'b0, 1'b0, 12);
    clear_counts();
    hold(1'b1, 1'b0, 12); hold(1'b1, 1'b1, 12);
    chk_int("stop_not_busy", n_stop, 1);
    chk_int("busy_stays_low", n_busy, 0);

    // Simultaneous SCL/SDA edges.
    filt_n = 8'd0;
    clear_counts();
    hold(1'b0, 1'b0, 8); hold(1'b1, 1'b1, 8);
    chk_int("simul_conditions", n_start + n_rstart + n_stop, 0);
    chk_int("simul_posedge", n_pos, 1);
    chk_int("simul_negedge", n_neg, 1);

    // Idle detection after STOP, threshold 10.
    hold(1'b1, 1'b0, 8);
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      step(1'b1, 1'b1);
      if (bus_if.stop_det_o === 1'b1) seen = 1'b1;
    end
    chk("idle_stop_seen", seen, 1'b1);
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, 1'b1);
      if (lat == 0 && bus_if.bus_idle_o === 1'b1) lat = j;
    end
    chk_int("idle_latency", lat, 11);
    hold(1'b1, 1'b0, 8);
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      step(1'b1, 1'b1);
      if (bus_if.stop_det_o === 1'b1) seen = 1'b1;
    end
    chk("idle2_stop_seen", seen, 1'b1);
    clear_counts();
    hold(1'b1, 1'b1, 3); hold(1'b1, 1'b0, 3); hold(1'b1, 1'b1, 6);
    chk_int("idle_interrupted", n_idle, 0);
    hold(1'b1, 1'b1, 20);

    // Enable off: levels and edges only.
    en = 1'b0;
    clear_counts();
    hold(1'b1, 1'b1, 8); hold(1'b1, 1'b0, 8); hold(1'b0, 1'b0, 8);
    hold(1'b1, 1'b0, 8); hold(1'b1, 1'b1, 8);
    chk_int("disabled_conditions", n_start + n_rstart + n_stop, 0);
    chk_int("disabled_busy", n_busy, 0);
    chk_int("disabled_idle", n_idle, 0);
    chk_int("disabled_posedge", n_pos, 1);
    chk_int("disabled_negedge", n_neg, 1);
    en = 1'b1;

    // Random line activity with varying thresholds and occasional disable.
    for (int k = 0; k < 80; k++) begin
      filt_n = 8'($urandom_range(0, 4));
      idle_n = 16'($urandom_range(0, 12));
      en = ($urandom_range(0, 7) != 0);
      rp = 2'($urandom);
      hold(rp[0], rp[1], $urandom_range(1, 10));
    end
    en = 1'b1;
    hold(1'b1, 1'b1, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
